dynode_integrator: RTL and testbench
====================================

// Module: dynode_integrator
// PURPOSE
//  Upstream producer for dynode_pileup. Forms one dynode energy integration per discriminator trigger:
//  start delay, then baseline-subtracted sum of ADC samples, ended by full count or by a pileup trigger.
//  Presents {dyn_energy, dyn_ingcnt, evntim} with a one-cycle ene_load strobe, spaced so the pileup FSM
//  (4-cycle event loop, accepts only while idle) never misses a load.
// PARAMETERS
//  ENE_SHIFT  0  right shift applied to 16-bit accumulator before 12-bit saturation
//  MIN_GAP    4  minimum clk cycles between ene_load pulses (>=1)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  adc_data       in   12  dynode ADC sample, one per clk
//  baseline       in   12  baseline subtracted from every sample
//  dyn_trig       in   1   discriminator strobe, one cycle per candidate event
//  trig_time      in   24  event time for dyn_trig; [11:8] = 1/16-clock phase
//  integstartdly  in   4   clks from trigger to first integrated sample
//  integcount     in   4   samples in a full integration; 0 = integrator disabled
//  dyn_energy     out  12  saturated energy sum
//  dyn_ingcnt     out  4   samples actually integrated (1..integcount)
//  evntim         out  24  trig_time latched at event start
//  ene_load       out  1   one-cycle strobe: outputs above valid
//  busy           out  1   FSM not in IDLE
//  drop_cnt       out  16  saturating count of discarded triggers/events
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, accumulator/counters/pending flag/gap counter cleared. Reset mid-event
//   discards it; no ene_load.
//  FSM states IDLE, DELAY, INTEG:
//   IDLE:  dyn_trig & integcount!=0 -> latch trig_time, dly=integstartdly;
//          next DELAY if dly!=0, else INTEG. dyn_trig & integcount==0 -> drop_cnt++, stay IDLE.
//   DELAY: dly decrements each clk; at 1 -> INTEG. dyn_trig here -> drop_cnt++, ignored.
//   INTEG: each clk without dyn_trig: acc += max(adc_data-baseline,0) (12-bit clamp, 16-bit acc), n++.
//          When n reaches integcount, including this sample -> finish, IDLE.
//          dyn_trig in INTEG (pileup) -> this sample NOT added. Finish with n so far; drop_cnt++ if n==0.
//          Then restart for the new trigger exactly as from IDLE, same cycle.
//  integstartdly/integcount sampled at trigger acceptance; later changes do not affect event in flight.
//  Finish: energy = min(acc>>ENE_SHIFT, 12'hFFF); ingcnt = n; evntim = latched time -> output stage.
//  Output stage: gap counter loads MIN_GAP-1 on each ene_load, counts to 0.
//   Finish with gap==0 and nothing pending -> registered outputs update and ene_load=1 next clk.
//   Latency: last sample cycle -> ene_load 1 clk later.
//   Finish while gap!=0 -> held in one-entry pending register; emitted the clk after gap reaches 0.
//   Finish while pending occupied -> new event discarded, drop_cnt++.
//   Pending and gap==0 on same clk as a new finish -> pending emitted; new event enters pending.
//  dyn_energy/dyn_ingcnt/evntim hold last emitted values between strobes.
//  ene_load never asserted on consecutive clks when MIN_GAP>=2.
//  drop_cnt saturates at 16'hFFFF.
// TESTING
//  1 integstartdly=2, integcount=4, baseline=100, adc=600 constant, trig_time=24'h000A00:
//    ene_load once, 7 clks after trig; dyn_energy=2000, dyn_ingcnt=4, evntim=24'h000A00.
//  2 integcount=8, 2nd dyn_trig on 3rd INTEG clk, adc-baseline=500:
//    ev1 energy=1000, ingcnt=2. ev2 full 8 samples. ene_load pulses >=MIN_GAP apart. drop_cnt=0.
//  3 adc=4095, baseline=0, integcount=15, ENE_SHIFT=0:
//    dyn_energy=12'hFFF (saturated), ingcnt=15.
//  4 adc<baseline on all samples: dyn_energy=0, ingcnt=integcount, ene_load still pulses.
//  5 dyn_trig in DELAY, integcount=0 trigger, and pileup trigger on 1st INTEG clk:
//    each drop_cnt++. No ene_load for the zero-sample or ignored cases.
//  6 reset asserted mid-INTEG with pending event held: next clk all outputs 0, no ene_load, busy=0.
//    Fresh trigger afterwards integrates normally.

Source files
------------

// File: rtl/dynode_integrator_if.sv
// Bundles the dynode_integrator sample/trigger inputs and event outputs.
// The master drives samples and triggers; the slave is the integrator.
interface dynode_integrator_if;
    logic [11:0] adc_data;
    logic [11:0] baseline;
    logic        dyn_trig;
    logic [23:0] trig_time;
    logic [3:0]  integstartdly;
    logic [3:0]  integcount;
    logic [11:0] dyn_energy;
    logic [3:0]  dyn_ingcnt;
    logic [23:0] evntim;
    logic        ene_load;
    logic        busy;
    logic [15:0] drop_cnt;

    modport master (
        output adc_data, baseline, dyn_trig, trig_time, integstartdly, integcount,
        input  dyn_energy, dyn_ingcnt, evntim, ene_load, busy, drop_cnt
    );

    modport slave (
        input  adc_data, baseline, dyn_trig, trig_time, integstartdly, integcount,
        output dyn_energy, dyn_ingcnt, evntim, ene_load, busy, drop_cnt
    );
endinterface

// File: rtl/dynode_integrator.sv
// Per-trigger dynode energy integrator: start delay, baseline-subtracted sum, pileup cut-off,
// and a gap-spaced output stage with a one-entry pending buffer feeding dynode_pileup.
module dynode_integrator #(
    parameter int unsigned ENE_SHIFT = 0,
    parameter int unsigned MIN_GAP   = 4
) (
    input logic                i_clk,
    input logic                i_reset,
    dynode_integrator_if.slave bus
);
    localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'(MIN_GAP - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StInteg} state_e;

    state_e          r_state;
    logic [3:0]      r_dly;
    logic [3:0]      r_max;
    logic [3:0]      r_n;
    logic [15:0]     r_acc;
    logic [23:0]     r_time;
    logic [GapW-1:0] r_gap;
    logic            r_pend;
    logic [11:0]     r_pend_energy;
    logic [3:0]      r_pend_n;
    logic [23:0]     r_pend_time;
    logic [11:0]     r_energy;
    logic [3:0]      r_ingcnt;
    logic [23:0]     r_evntim;
    logic            r_load;
    logic            r_busy;
    logic [15:0]     r_drop;

    logic [11:0] w_diff;
    logic [15:0] w_acc_sum;
    logic [3:0]  w_n_inc;
    logic        w_accept;
    logic        w_fin;
    logic [15:0] w_fin_acc;
    logic [3:0]  w_fin_n;
    logic [1:0]  w_drop_fsm;
    logic [15:0] w_shift;
    logic [11:0] w_fin_energy;
    logic        w_gap_zero;
    logic        w_emit_pend;
    logic        w_emit_fin;
    logic        w_drop_out;
    logic [16:0] w_drop_sum;

    assign w_diff    = (bus.adc_data > bus.baseline) ? bus.adc_data - bus.baseline : 12'd0;
    assign w_acc_sum = r_acc + {4'd0, w_diff};
    assign w_n_inc   = r_n + 4'd1;

    // A pileup trigger may both close the running event and open (or drop) a new one.
    always_comb begin
        w_accept   = 1'b0;
        w_fin      = 1'b0;
        w_fin_acc  = w_acc_sum;
        w_fin_n    = w_n_inc;
        w_drop_fsm = 2'd0;
        case (r_state)
            StIdle: begin
                if (bus.dyn_trig) begin
                    if (bus.integcount != 4'd0) w_accept = 1'b1;
                    else                        w_drop_fsm = 2'd1;
                end
            end
            StDelay: begin
                if (bus.dyn_trig) w_drop_fsm = 2'd1;
            end
            StInteg: begin
                if (bus.dyn_trig) begin
                    if (r_n != 4'd0) begin
                        w_fin     = 1'b1;
                        w_fin_acc = r_acc;
                        w_fin_n   = r_n;
                    end else begin
                        w_drop_fsm = 2'd1;
                    end
                    if (bus.integcount != 4'd0) w_accept = 1'b1;
                    else                        w_drop_fsm = w_drop_fsm + 2'd1;
                end else if (w_n_inc == r_max) begin
                    w_fin = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign w_shift      = w_fin_acc >> ENE_SHIFT;
    assign w_fin_energy = (|w_shift[15:12]) ? 12'hFFF : w_shift[11:0];
    assign w_gap_zero   = (r_gap == '0);
    assign w_emit_pend  = r_pend & w_gap_zero;
    assign w_emit_fin   = w_fin & ~r_pend & w_gap_zero;
    assign w_drop_out   = w_fin & r_pend & ~w_gap_zero;
    assign w_drop_sum   = {1'b0, r_drop} + 17'(w_drop_fsm) + 17'(w_drop_out);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_dly         <= '0;
            r_max         <= '0;
            r_n           <= '0;
            r_acc         <= '0;
            r_time        <= '0;
            r_gap         <= '0;
            r_pend        <= 1'b0;
            r_pend_energy <= '0;
            r_pend_n      <= '0;
            r_pend_time   <= '0;
            r_energy      <= '0;
            r_ingcnt      <= '0;
            r_evntim      <= '0;
            r_load        <= 1'b0;
            r_busy        <= 1'b0;
            r_drop        <= '0;
        end else begin
            r_load <= w_emit_pend | w_emit_fin;
            if (w_emit_pend) begin
                r_energy <= r_pend_energy;
                r_ingcnt <= r_pend_n;
                r_evntim <= r_pend_time;
            end else if (w_emit_fin) begin
                r_energy <= w_fin_energy;
                r_ingcnt <= w_fin_n;
                r_evntim <= r_time;
            end
            if (w_emit_pend | w_emit_fin) r_gap <= GapLoad;
            else if (!w_gap_zero)         r_gap <= r_gap - GapW'(1);

            // A finish parks in pending when it cannot go out now and the slot is (being) freed.
            if (w_fin && !w_emit_fin && (w_emit_pend || !r_pend)) begin
                r_pend        <= 1'b1;
                r_pend_energy <= w_fin_energy;
                r_pend_n      <= w_fin_n;
                r_pend_time   <= r_time;
            end else if (w_emit_pend) begin
                r_pend <= 1'b0;
            end
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

            if (w_accept) begin
                r_time  <= bus.trig_time;
                r_max   <= bus.integcount;
                r_dly   <= bus.integstartdly;
                r_acc   <= '0;
                r_n     <= '0;
                r_state <= (bus.integstartdly != 4'd0) ? StDelay : StInteg;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    StDelay: begin
                        if (r_dly == 4'd1) r_state <= StInteg;
                        else               r_dly   <= r_dly - 4'd1;
                    end
                    StInteg: begin
                        if (bus.dyn_trig || (w_n_inc == r_max)) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_acc <= w_acc_sum;
                            r_n   <= w_n_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dyn_energy = r_energy;
    assign bus.dyn_ingcnt = r_ingcnt;
    assign bus.evntim     = r_evntim;
    assign bus.ene_load   = r_load;
    assign bus.busy       = r_busy;
    assign bus.drop_cnt   = r_drop;
endmodule

// File: tb/tb_dynode_integrator.sv
// Bench for dynode_integrator: directed scenarios then random traffic, every cycle compared
// against an event-level model that works in absolute cycle numbers.
module tb_dynode_integrator;
    localparam int EneShift = 0;
    localparam int MinGap   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dynode_integrator_if dif ();

    dynode_integrator #(
        .ENE_SHIFT(EneShift),
        .MIN_GAP  (MinGap)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (dif.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model state: current event described by its first-sample cycle and running totals.
    int m_t = 0;
    bit m_active;
    int m_first, m_max, m_acc, m_n, m_time;
    int m_last;
    bit p_valid;
    int p_acc, p_n, p_time;
    int e_load, e_energy, e_ingcnt, e_time, e_busy, e_drop;

    // Stimulus state and observed load log.
    logic [3:0]  s_isd, s_icnt;
    logic [11:0] s_adc, s_base;
    int ld_energy[$];
    int ld_n[$];
    int ld_time[$];
    int ld_t[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; p_valid = 0; m_last = -100;
        m_acc = 0; m_n = 0;
        e_load = 0; e_energy = 0; e_ingcnt = 0; e_time = 0; e_busy = 0; e_drop = 0;
    endtask

    task automatic model_emit(input int acc, input int n, input int tm, input int cur);
        int en;
        en = acc >> EneShift;
        e_load = 1; e_energy = (en > 4095) ? 4095 : en; e_ingcnt = n; e_time = tm;
        m_last = cur + 1;
    endtask

    task automatic model_step(input bit trig, input int tt, input int isd, input int icnt,
                              input int adc, input int base);
        int cur, drops, f_acc, f_n, f_time;
        bit fin, start, gap_ok;
        cur = m_t; drops = 0; fin = 0; start = 0;
        f_acc = 0; f_n = 0; f_time = 0;
        if (!m_active) begin
            start = trig;
        end else if (cur < m_first) begin
            if (trig) drops++;
        end else if (trig) begin
            if (m_n > 0) begin fin = 1; f_acc = m_acc; f_n = m_n; f_time = m_time; end
            else drops++;
            m_active = 0;
            start = 1;
        end else begin
            m_acc += (adc > base) ? adc - base : 0;
            m_n++;
            if (m_n == m_max) begin
                fin = 1; f_acc = m_acc; f_n = m_n; f_time = m_time; m_active = 0;
            end
        end
        if (start) begin
            if (icnt != 0) begin
                m_active = 1; m_first = cur + isd + 1; m_max = icnt;
                m_acc = 0; m_n = 0; m_time = tt;
            end else drops++;
        end
        e_load = 0;
        gap_ok = (cur + 1 >= m_last + MinGap);
        if (p_valid && gap_ok) begin
            model_emit(p_acc, p_n, p_time, cur);
            p_valid = fin;
            p_acc = f_acc; p_n = f_n; p_time = f_time;
        end else if (fin) begin
            if (!p_valid && gap_ok) model_emit(f_acc, f_n, f_time, cur);
            else if (!p_valid) begin
                p_valid = 1; p_acc = f_acc; p_n = f_n; p_time = f_time;
            end else drops++;
        end
        e_drop = (e_drop + drops > 65535) ? 65535 : e_drop + drops;
        e_busy = m_active;
    endtask

    task automatic step(input bit trig, input logic [23:0] tt, input bit rst);
        reset             = rst;
        dif.dyn_trig      = trig;
        dif.trig_time     = tt;
        dif.integstartdly = s_isd;
        dif.integcount    = s_icnt;
        dif.adc_data      = s_adc;
        dif.baseline      = s_base;
        if (rst) model_reset();
        else model_step(trig, int'(tt), int'(s_isd), int'(s_icnt), int'(s_adc), int'(s_base));
        m_t++;
        @(posedge clk);
        #1;
        chk("ene_load", int'(dif.ene_load), e_load);
        chk("dyn_energy", int'(dif.dyn_energy), e_energy);
        chk("dyn_ingcnt", int'(dif.dyn_ingcnt), e_ingcnt);
        chk("evntim", int'(dif.evntim), e_time);
        chk("busy", int'(dif.busy), e_busy);
        chk("drop_cnt", int'(dif.drop_cnt), e_drop);
        if (dif.ene_load) begin
            ld_energy.push_back(int'(dif.dyn_energy));
            ld_n.push_back(int'(dif.dyn_ingcnt));
            ld_time.push_back(int'(dif.evntim));
            ld_t.push_back(m_t);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 24'd0, 1'b0);
    endtask

    task automatic pulse(input logic [23:0] tt);
        step(1'b1, tt, 1'b0);
    endtask

    initial begin
        int l0, t0, sep;
        bit rs, tg;
        s_isd = 0; s_icnt = 0; s_adc = 0; s_base = 0;
        model_reset();
        step(1'b0, 24'd0, 1'b1);
        step(1'b0, 24'd0, 1'b1);

        // Plain event: latency, sum and latched time.
        s_isd = 2; s_icnt = 4; s_base = 100; s_adc = 600;
        l0 = ld_t.size(); t0 = m_t;
        pulse(24'h000A00);
        idle(10);
        chk("t1_loads", ld_t.size() - l0, 1);
        if (ld_t.size() > l0) begin
            chk("t1_latency", ld_t[l0] - t0, 7);
            chk("t1_energy", ld_energy[l0], 2000);
            chk("t1_ingcnt", ld_n[l0], 4);
            chk("t1_evntim", ld_time[l0], 24'h000A00);
        end

        // Pileup on the third integration clock.
        s_isd = 0; s_icnt = 8;
        l0 = ld_t.size();
        pulse(24'h000111);
        idle(2);
        pulse(24'h000222);
        idle(14);
        chk("t2_loads", ld_t.size() - l0, 2);
        if (ld_t.size() > l0 + 1) begin
            chk("t2_ev1_energy", ld_energy[l0], 1000);
            chk("t2_ev1_ingcnt", ld_n[l0], 2);
            chk("t2_ev2_energy", ld_energy[l0 + 1], 4000);
            chk("t2_ev2_ingcnt", ld_n[l0 + 1], 8);
            sep = ld_t[l0 + 1] - ld_t[l0];
            chk("t2_gap_ok", int'(sep >= MinGap), 1);
        end
        chk("t2_drop", int'(dif.drop_cnt), 0);

        // Saturation.
        s_isd = 1; s_icnt = 15; s_adc = 12'hFFF; s_base = 0;
        l0 = ld_t.size();
        pulse(24'h123456);
        idle(20);
        chk("t3_loads", ld_t.size() - l0, 1);
        if (ld_t.size() > l0) begin
            chk("t3_energy", ld_energy[l0], 12'hFFF);
            chk("t3_ingcnt", ld_n[l0], 15);
        end

        // Samples all below baseline.
        s_isd = 0; s_icnt = 5; s_adc = 50; s_base = 100;
        l0 = ld_t.size();
        pulse(24'h000333);
        idle(10);
        chk("t4_loads", ld_t.size() - l0, 1);
        if (ld_t.size() > l0) begin
            chk("t4_energy", ld_energy[l0], 0);
            chk("t4_ingcnt", ld_n[l0], 5);
        end

        // Drops: trigger in delay, disabled integrator, pileup with zero samples.
        s_isd = 3; s_icnt = 2; s_adc = 300; s_base = 100;
        l0 = ld_t.size();
        pulse(24'h000444);
        idle(1);
        pulse(24'h000555);
        idle(8);
        s_icnt = 0;
        pulse(24'h000666);
        idle(2);
        s_isd = 0; s_icnt = 3;
        pulse(24'h000777);
        pulse(24'h000888);
        idle(8);
        chk("t5_drop", int'(dif.drop_cnt), 3);
        chk("t5_loads", ld_t.size() - l0, 2);
        if (ld_t.size() > l0 + 1) begin
            chk("t5_last_time", ld_time[l0 + 1], 24'h000888);
            chk("t5_last_ingcnt", ld_n[l0 + 1], 3);
        end

        // Reset while integrating with an event held in pending.
        s_isd = 0; s_icnt = 2; s_adc = 600; s_base = 100;
        pulse(24'h000999);
        idle(2);
        s_icnt = 8;
        pulse(24'h000AAA);
        idle(1);
        pulse(24'h000BBB);
        l0 = ld_t.size();
        step(1'b0, 24'd0, 1'b1);
        chk("t6_load", int'(dif.ene_load), 0);
        chk("t6_energy", int'(dif.dyn_energy), 0);
        chk("t6_busy", int'(dif.busy), 0);
        chk("t6_evntim", int'(dif.evntim), 0);
        idle(6);
        chk("t6_no_load", ld_t.size() - l0, 0);
        s_isd = 2; s_icnt = 4;
        pulse(24'h000A00);
        idle(10);
        chk("t6_fresh_loads", ld_t.size() - l0, 1);
        if (ld_t.size() > l0) begin
            chk("t6_fresh_energy", ld_energy[l0], 2000);
            chk("t6_fresh_ingcnt", ld_n[l0], 4);
        end

        // Random traffic; delay and count change every clock to exercise capture at acceptance.
        for (int i = 0; i < 2000; i++) begin
            rs = ($urandom_range(0, 399) == 0);
            tg = ($urandom_range(0, 5) == 0);
            s_isd  = 4'($urandom_range(0, 4));
            s_icnt = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            s_adc  = 12'($urandom_range(0, 4095));
            s_base = 12'($urandom_range(0, 1500));
            step(tg, 24'($urandom), rs);
        end
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
